// File: rtl/tube_scan_decoder.sv
// Receive side of the multiplexed seven-segment tube bus: waits for each digit to dwell stably,
// decodes it back to BCD and publishes complete 7-digit distance/price frames atomically.
module tube_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] tube_11bit,
    output logic [3:0]  distan_thous,
    output logic [3:0]  distan_hundr,
    output logic [3:0]  distan_tens,
    output logic [3:0]  distan_units,
    output logic [3:0]  price_hundr,
    output logic [3:0]  price_tens,
    output logic [3:0]  price_units,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        frame_stale
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    // Sampler resets to a blanking word so an idle bus never looks like a stable digit 0.
    localparam logic [10:0] BLANK_WORD = 11'h780;

    typedef enum logic {TRACK = 1'b0, HELD = 1'b1} state_t;

    logic [10:0]   s0_q, s1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [6:0]    seen_q, seen_d;
    logic [3:0]    shadow_q [7];
    logic [3:0]    shadow_d [7];
    logic [3:0]    disp_q [7];
    logic [3:0]    disp_d [7];
    logic [TW-1:0] to_q, to_d;
    logic          stale_q, stale_d;
    logic          fv_q, fv_d;
    logic          se_q, se_d;

    logic          stable, capture, publish, timeout;
    logic          dec_ok;
    logic [3:0]    dec_bcd;

    assign stable  = (s0_q == s1_q) && (s0_q[10:7] <= 4'd6);
    assign capture = stable && (state_q == TRACK) && (cnt_q >= CNT_CAP);
    assign publish = (seen_q == 7'h7F);
    assign timeout = !capture && (to_q == TO_MAX);

    always_comb begin
        dec_ok  = 1'b1;
        dec_bcd = 4'd0;
        case (s0_q[6:0])
            7'h3F:   dec_bcd = 4'd0;
            7'h06:   dec_bcd = 4'd1;
            7'h5B:   dec_bcd = 4'd2;
            7'h4F:   dec_bcd = 4'd3;
            7'h66:   dec_bcd = 4'd4;
            7'h6D:   dec_bcd = 4'd5;
            7'h7D:   dec_bcd = 4'd6;
            7'h07:   dec_bcd = 4'd7;
            7'h7F:   dec_bcd = 4'd8;
            7'h6F:   dec_bcd = 4'd9;
            default: dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d    = '0;
        state_d  = TRACK;
        seen_d   = (publish || timeout) ? 7'h00 : seen_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        to_d     = (capture || timeout) ? '0 : to_q + TW'(1);
        stale_d  = stale_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;

        if (stable) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            state_d = (capture || state_q == HELD) ? HELD : TRACK;
        end

        // Illegal patterns still consume the dwell so one bad digit raises one error.
        if (capture) begin
            if (dec_ok) begin
                shadow_d[s0_q[9:7]] = dec_bcd;
                seen_d[s0_q[9:7]]   = 1'b1;
            end else begin
                se_d = 1'b1;
            end
        end

        if (publish) begin
            disp_d  = shadow_q;
            fv_d    = 1'b1;
            stale_d = 1'b0;
        end

        if (timeout) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_q    <= BLANK_WORD;
            s1_q    <= BLANK_WORD;
            cnt_q   <= '0;
            state_q <= TRACK;
            seen_q  <= '0;
            to_q    <= '0;
            stale_q <= 1'b0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            s0_q     <= tube_11bit;
            s1_q     <= s0_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            seen_q   <= seen_d;
            to_q     <= to_d;
            stale_q  <= stale_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    assign distan_units = disp_q[0];
    assign distan_tens  = disp_q[1];
    assign distan_hundr = disp_q[2];
    assign distan_thous = disp_q[3];
    assign price_units  = disp_q[4];
    assign price_tens   = disp_q[5];
    assign price_hundr  = disp_q[6];
    assign frame_valid  = fv_q;
    assign seg_error    = se_q;
    assign frame_stale  = stale_q;

endmodule
